// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and helpers for the multi-cycle execute ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SRL   = 4'd9;
    localparam logic [3:0] ALU_COPYB = 4'd10;
    localparam logic [3:0] ALU_MUL   = 4'd11;
    localparam logic [3:0] ALU_MULHU = 4'd12;
    localparam logic [3:0] ALU_DIVU  = 4'd13;
    localparam logic [3:0] ALU_REMU  = 4'd14;
    localparam logic [3:0] ALU_NOP   = 4'd15;

    // Iterator sub-op: bit 1 selects division, bit 0 selects the upper half of the result
    localparam logic [1:0] MD_MUL   = 2'd0;
    localparam logic [1:0] MD_MULHU = 2'd1;
    localparam logic [1:0] MD_DIVU  = 2'd2;
    localparam logic [1:0] MD_REMU  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one hi/lo register pair.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_r, lo_r, mcand_r;
    logic [CW-1:0]    cnt_r;
    logic             run_r;
    logic [1:0]       op_r;

    logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
    logic [WIDTH-1:0] hi_next_s, lo_next_s;

    // Next iteration value; done/result look ahead so the caller can register them on the last edge
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mcand_r};
        hi_next_s   = hi_r;
        lo_next_s   = lo_r;
        if (op_r[1]) begin
            if (!div_diff_s[WIDTH]) begin
                hi_next_s = div_diff_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_next_s = div_shift_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next_s = mul_sum_s[WIDTH:1];
            lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
        done = run_r && (cnt_r == CW'(WIDTH-1));
        case (op_r)
            MD_MUL:   result = lo_next_s;
            MD_MULHU: result = hi_next_s;
            MD_DIVU:  result = lo_next_s;
            MD_REMU:  result = hi_next_s;
            default:  result = {WIDTH{1'b0}};
        endcase
    end

    // Operand load on start, then one iteration per cycle until the counter wraps
    always_ff @(posedge clk) begin
        if (!rst_n || kill) begin
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            run_r   <= 1'b0;
            op_r    <= MD_MUL;
        end else if (start) begin
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= op[1] ? A : B;
            mcand_r <= op[1] ? B : A;
            cnt_r   <= {CW{1'b0}};
            run_r   <= 1'b1;
            op_r    <= op;
        end else if (run_r) begin
            hi_r  <= hi_next_s;
            lo_r  <= lo_next_s;
            cnt_r <= cnt_r + CW'(1);
            if (done) begin
                run_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle ops complete in one edge, mul/div iterate WIDTH cycles.
module alu_mc
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             busy
);

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] out_r, out_next_s, alu_s, md_result_s;
    logic             out_valid_r, in_ready_r, busy_r;
    logic             accept_s, md_start_s, md_done_s;
    logic [1:0]       md_op_s;
    logic [SHW-1:0]   shamt_s;

    assign accept_s  = in_valid & in_ready_r & ~kill;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign Out       = out_r;

    // Single-cycle datapath and iterator sub-op decode
    always_comb begin
        shamt_s = B[SHW-1:0];
        case (ALUop)
            ALU_ADD:   alu_s = A + B;
            ALU_SUB:   alu_s = A - B;
            ALU_AND:   alu_s = A & B;
            ALU_OR:    alu_s = A | B;
            ALU_XOR:   alu_s = A ^ B;
            ALU_SLT:   alu_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU:  alu_s = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:   alu_s = A << shamt_s;
            ALU_SRA:   alu_s = $unsigned($signed(A) >>> shamt_s);
            ALU_SRL:   alu_s = A >> shamt_s;
            ALU_COPYB: alu_s = B;
            ALU_NOP:   alu_s = {WIDTH{1'b0}};
            default:   alu_s = {WIDTH{1'b0}};
        endcase
        case (ALUop)
            ALU_MUL:   md_op_s = MD_MUL;
            ALU_MULHU: md_op_s = MD_MULHU;
            ALU_DIVU:  md_op_s = MD_DIVU;
            ALU_REMU:  md_op_s = MD_REMU;
            default:   md_op_s = MD_MUL;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .kill   (kill),
        .start  (md_start_s),
        .op     (md_op_s),
        .A      (A),
        .B      (B),
        .done   (md_done_s),
        .result (md_result_s)
    );

    // Next state and next result; Out is forced to zero whenever the block leaves DONE
    always_comb begin
        state_next_s = state_r;
        out_next_s   = out_r;
        md_start_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (is_multicycle(ALUop)) begin
                        state_next_s = S_BUSY;
                        md_start_s   = 1'b1;
                    end else begin
                        state_next_s = S_DONE;
                        out_next_s   = alu_s;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (kill) begin
                    state_next_s = S_IDLE;
                    out_next_s   = {WIDTH{1'b0}};
                end else if (md_done_s) begin
                    state_next_s = S_DONE;
                    out_next_s   = md_result_s;
                end else begin
                    state_next_s = S_BUSY;
                end
            end
            S_DONE: begin
                if (kill || out_ready) begin
                    state_next_s = S_IDLE;
                    out_next_s   = {WIDTH{1'b0}};
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                out_next_s   = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, result and handshake flags, all registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            out_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_r       <= out_next_s;
            out_valid_r <= (state_next_s == S_DONE);
            in_ready_r  <= (state_next_s == S_IDLE);
            busy_r      <= (state_next_s != S_IDLE);
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus queues expected results, a negedge monitor checks each transfer.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, kill, out_valid, out_ready, busy;
    logic [W-1:0] A, B, Out;
    logic [3:0]   ALUop;

    typedef struct {
        logic [W-1:0] val;
        int           acc;
        int           lat;
        string        name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   xfers = 0;
    bit   seen_valid = 1'b0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUop     (ALUop),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: latency on first sight of out_valid, value on the handshake cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_valid = 1'b0;
        end else if (out_valid) begin
            if (!seen_valid) begin
                seen_valid = 1'b1;
                if (sbq.size() == 0) check("unexpected_output", 64'(Out), 64'hDEAD);
                else check({sbq[0].name, "_lat"}, 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
            end
            if (out_ready) begin
                xfers++;
                if (sbq.size() != 0) begin
                    check(sbq[0].name, 64'(Out), 64'(sbq[0].val));
                    void'(sbq.pop_front());
                end
                seen_valid = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] expv, input int lat, input string nm);
        wait_ready();
        ALUop = op; A = a; B = b; in_valid = 1'b1;
        if (push) sbq.push_back('{val: expv, acc: cyc, lat: lat, name: nm});
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 32'hA5A5_5A5A; B = 32'h5A5A_A5A5; ALUop = 4'd0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; ALUop = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out", 64'(Out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with in_ready timing around the handshake
        issue(4'd0, 32'd5, 32'd7, 1'b1, 32'd12, 1, "add");
        check("add_in_ready_t1", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("add_in_ready_t2", 64'(in_ready), 64'd1);
        check("add_out_valid_t2", 64'(out_valid), 64'd0);

        // Remaining single-cycle ops
        issue(4'd1, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1, "sub");
        issue(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'hFF00_EDCB, 1, "xor");
        issue(4'd8, 32'h8000_0000, 32'h0000_0024, 1'b1, 32'hF800_0000, 1, "sra");
        issue(4'd9, 32'h8000_0000, 32'h0000_0024, 1'b1, 32'h0800_0000, 1, "srl");
        issue(4'd7, 32'h0000_0003, 32'h0000_003F, 1'b1, 32'h8000_0000, 1, "sll");
        issue(4'd5, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 1, "slt");
        issue(4'd6, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1, "sltu");
        issue(4'd10, 32'd3, 32'h1234_5678, 1'b1, 32'h1234_5678, 1, "copyb");
        issue(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0, 1, "nop");

        // Iterative ops, including divide by zero
        issue(4'd11, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0, 33, "mul");
        issue(4'd12, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd1, 33, "mulhu");
        issue(4'd11, 32'd7, 32'd6, 1'b1, 32'd42, 33, "mul_small");
        issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 33, "mulhu_max");
        issue(4'd13, 32'd100, 32'd7, 1'b1, 32'd14, 33, "divu");
        issue(4'd14, 32'd100, 32'd7, 1'b1, 32'd2, 33, "remu");
        issue(4'd13, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 33, "divu_zero");
        issue(4'd14, 32'd5, 32'd0, 1'b1, 32'd5, 33, "remu_zero");
        issue(4'd13, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd1, 33, "divu_big");
        drain();

        // Backpressure after a MULHU: Out holds, new requests ignored, one transfer
        out_ready = 1'b0;
        issue(4'd12, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 33, "bp_mulhu");
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("bp_valid_seen", 64'(out_valid), 64'd1);
        ALUop = 4'd0; A = 32'd1; B = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_stable", 64'(Out), 64'd1);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_valid_held", 64'(out_valid), 64'd1);
        end
        x0 = xfers;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_one_transfer", 64'(xfers - x0), 64'd1);
        check("bp_valid_dropped", 64'(out_valid), 64'd0);

        // kill 10 cycles into DIVU discards the result
        issue(4'd13, 32'd100, 32'd7, 1'b0, 32'd0, 0, "killed");
        repeat (9) @(posedge clk);
        #1;
        check("kill_busy_before", 64'(busy), 64'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_in_ready", 64'(in_ready), 64'd1);
        check("kill_out_valid", 64'(out_valid), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("kill_no_output", 64'(out_valid), 64'd0);

        // kill in IDLE beats in_valid
        ALUop = 4'd0; A = 32'd3; B = 32'd4; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check("kill_idle_in_ready", 64'(in_ready), 64'd1);
        check("kill_idle_out_valid", 64'(out_valid), 64'd0);

        // Reset mid-MUL, then a fresh ADD
        issue(4'd11, 32'd9, 32'd9, 1'b0, 32'd0, 0, "reset_mul");
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_out", 64'(Out), 64'd0);
        check("rst2_busy", 64'(busy), 64'd0);
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        issue(4'd0, 32'd1, 32'd1, 1'b1, 32'd2, 1, "add_after_rst");
        drain();
        repeat (40) @(posedge clk);
        #1;
        check("final_idle", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
